mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MEM_LAT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cpu_req  input  1  CPU (MAR/MDR path) transaction request; held high until cpu_done.
REQ-007 cpu_rw  input  1  CPU access type: 0 = read, 1 = write.
REQ-008 cpu_addr  input  ADDR_W  CPU address.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
REQ-011 cpu_done  output  1  one-cycle pulse: CPU transaction complete.
REQ-012 cpu_rdata  output  DATA_W  CPU read data; valid from cpu_done, held until the next CPU read completes.
REQ-013 dma_req, dma_rw, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same directions, widths and meanings as the cpu_* ports, for the I/O DMA requester.
REQ-014 mem_en  output  1  memory enable.
REQ-015 mem_rw  output  1  memory access type: 0 = read, 1 = write.
REQ-016 mem_addr  output  ADDR_W  memory address.
REQ-017 mem_wdata  output  DATA_W  memory write data.
REQ-018 mem_rdata  input  DATA_W  memory read data; valid in the last enabled cycle.

Function
REQ-019 FSM states: IDLE, BUSY, DONE. The block has no other states.
REQ-020 IDLE with any req high at edge N -> BUSY; winner's rw/addr/wdata registered; winner's gnt high during cycle N+1 only.
REQ-021 BUSY lasts exactly MEM_LAT cycles, counted by a down-counter; mem_en = 1 throughout; mem_rw/mem_addr/mem_wdata come from the registered values and are stable.
REQ-022 Last BUSY cycle: mem_rdata is captured into the owner's rdata register on reads; on writes the owner's rdata is unchanged.
REQ-023 DONE lasts one cycle; owner's done = 1 and mem_en = 0; next state is IDLE.
REQ-024 Latency: req sampled at edge N -> done high in cycle N+MEM_LAT+1 -> IDLE in cycle N+MEM_LAT+2. New grants occur only from IDLE, so back-to-back transactions are MEM_LAT+2 cycles apart.
REQ-025 Arbitration: round-robin on a last-owner bit. When both requests are high in IDLE, the requester that was not the last owner wins.
REQ-026 A single request is granted regardless of the last-owner bit.
REQ-027 A req deasserted after grant does not abort the transaction; done still pulses.
REQ-028 A req held high through its own DONE cycle is treated as a new request in the next IDLE cycle.
REQ-029 At most one gnt and one done are high in any cycle, and never for the non-owner.
REQ-030 In IDLE: mem_en = 0, and mem_rw/mem_addr/mem_wdata hold their last values.

Reset
REQ-031 rst asynchronously forces state IDLE, counter 0, last-owner = DMA (the CPU wins the first contention), and all outputs to 0 (gnt, done, rdata, mem_en, mem_rw, mem_addr, mem_wdata).
REQ-032 Reset during BUSY or DONE aborts the transaction with no done pulse and no rdata update.
REQ-033 After rst falls, the first grant is possible at the first clock edge.

Configuration
REQ-034 With MEM_ARB_CPU_PRIORITY_EN defined, arbitration is fixed priority: CPU always wins contention, and the last-owner bit is neither used nor implemented.
REQ-035 Without MEM_ARB_CPU_PRIORITY_EN, round-robin per REQ-025 applies.

Verification
REQ-036 MEM_LAT=2, CPU read of 0x3000 with the memory model returning 0x1234: cpu_gnt in cycle N+1, mem_en in cycles N+1..N+2, cpu_done in cycle N+3 with cpu_rdata = 0x1234.
REQ-037 DMA write of 0xBEEF to 0x4000: mem_rw = 1 and mem_wdata = 0xBEEF for 2 cycles, dma_done pulses once, dma_rdata is unchanged.
REQ-038 Both requests held high continuously for 4 transactions: grant order CPU, DMA, CPU, DMA, with grants every 4 cycles. With MEM_ARB_CPU_PRIORITY_EN defined: CPU on all 4 grants.
REQ-039 rst asserted in the second BUSY cycle of a CPU read: outputs are 0 immediately, no cpu_done, and cpu_rdata stays at 0.
REQ-040 cpu_req dropped one cycle after cpu_gnt: the transaction completes and cpu_done pulses exactly once. With MEM_LAT=1, the done pulse comes 2 cycles after the request edge.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (CPU / DMA) memory arbiter, IDLE/BUSY/DONE FSM.
//               Define MEM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead
//               of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_LAT_M1 = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("mem_arbiter: MEM_LAT out of range 1..15");
    end

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_owner;     // 0 = CPU, 1 = DMA
    logic       w_pick_dma;

`ifdef MEM_ARB_CPU_PRIORITY_EN
    assign w_pick_dma = !cpu_req;
`else
    logic r_last_owner;
    // Under contention the requester that did not own the last transaction wins.
    assign w_pick_dma = dma_req && (!cpu_req || !r_last_owner);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_owner   <= 1'b0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
            r_last_owner <= 1'b1;
`endif
            cpu_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            dma_gnt   <= 1'b0;
            dma_done  <= 1'b0;
            dma_rdata <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        r_state   <= BUSY;
                        r_owner   <= w_pick_dma;
`ifndef MEM_ARB_CPU_PRIORITY_EN
                        r_last_owner <= w_pick_dma;
`endif
                        cpu_gnt   <= !w_pick_dma;
                        dma_gnt   <= w_pick_dma;
                        r_cnt     <= C_LAT_M1;
                        mem_en    <= 1'b1;
                        mem_rw    <= w_pick_dma ? dma_rw    : cpu_rw;
                        mem_addr  <= w_pick_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= w_pick_dma ? dma_wdata : cpu_wdata;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= DONE;
                        mem_en   <= 1'b0;
                        cpu_done <= !r_owner;
                        dma_done <= r_owner;
                        // Read data is valid in the last enabled cycle.
                        if (!mem_rw) begin
                            if (r_owner) dma_rdata <= mem_rdata;
                            else         cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int LAT = 2;

    typedef struct {bit dma; int cyc;} gnt_t;
    typedef struct {bit dma; int cyc; logic [15:0] rdata;} done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // cyc at a negedge is the index of the cycle in progress.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        cpu_req = 0, cpu_rw = 0, dma_req = 0, dma_rw = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic        cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_rw;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        d1_req = 0;
    logic [15:0] d1_addr = 0;
    logic        d1_gnt, d1_done, d1_dgnt, d1_ddone, d1_en, d1_rw;
    logic [15:0] d1_rdata, d1_drdata, d1_maddr, d1_mwdata, d1_mrdata;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    assign mem_rdata = mem_model(mem_addr);
    assign d1_mrdata = mem_model(d1_maddr);

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(d1_req), .cpu_rw(zero1), .cpu_addr(d1_addr), .cpu_wdata(zero16),
        .cpu_gnt(d1_gnt), .cpu_done(d1_done), .cpu_rdata(d1_rdata),
        .dma_req(zero1), .dma_rw(zero1), .dma_addr(zero16), .dma_wdata(zero16),
        .dma_gnt(d1_dgnt), .dma_done(d1_ddone), .dma_rdata(d1_drdata),
        .mem_en(d1_en), .mem_rw(d1_rw), .mem_addr(d1_maddr), .mem_wdata(d1_mwdata),
        .mem_rdata(d1_mrdata)
    );

    int          tests = 0, fails = 0;
    int          en_cnt = 0, wr_cnt = 0;
    logic [15:0] exp_cpu = 0, exp_dma = 0;
    gnt_t        gq[$];
    done_t       dq[$];
    int          d1q[$];
    gnt_t        ge;
    done_t       de;
    int          d1e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit any_out();
        return |{cpu_gnt, cpu_done, cpu_rdata, dma_gnt, dma_done, dma_rdata,
                 mem_en, mem_rw, mem_addr, mem_wdata};
    endfunction

    // Monitor: pops the scoreboard whenever a grant or done appears.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) en_cnt++;
            if (mem_en && mem_rw && mem_addr == 16'h4000 && mem_wdata == 16'hBEEF) wr_cnt++;
            if (cpu_gnt && dma_gnt)   chk("dual_gnt", 1, 0);
            if (cpu_done && dma_done) chk("dual_done", 1, 0);
            if (cpu_gnt || dma_gnt) begin
                if (gq.size() == 0) chk("unexpected_gnt", 1, 0);
                else begin
                    ge = gq.pop_front();
                    chk("gnt_owner_cycle", {dma_gnt, 32'(cyc)}, {ge.dma, 32'(ge.cyc)});
                end
            end
            if (cpu_done || dma_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    de = dq.pop_front();
                    chk("done_owner_cycle_rdata",
                        {dma_done, 32'(cyc), (dma_done ? dma_rdata : cpu_rdata)},
                        {de.dma, 32'(de.cyc), de.rdata});
                end
            end
            if (d1_done) begin
                if (d1q.size() == 0) chk("d1_unexpected_done", 1, 0);
                else begin
                    d1e = d1q.pop_front();
                    chk("d1_done_cycle", 64'(cyc), 64'(d1e));
                end
            end
        end
    end

    task automatic wait_gnt(input bit dma, input string name);
        int n = 0;
        while (!(dma ? dma_gnt : cpu_gnt)) begin
            if (n == 20) begin chk({name, "_gnt_timeout"}, 1, 0); return; end
            @(negedge clk); n++;
        end
    endtask

    task automatic wait_done(input bit dma, input string name);
        int n = 0;
        while (!(dma ? dma_done : cpu_done)) begin
            if (n == 20) begin chk({name, "_done_timeout"}, 1, 0); return; end
            @(negedge clk); n++;
        end
    endtask

    task automatic drop(input bit dma);
        if (dma) dma_req = 0; else cpu_req = 0;
    endtask

    task automatic txn(input bit dma, input bit rw, input logic [15:0] addr,
                       input logic [15:0] wdata, input bit drop_early, input string name);
        gnt_t  g;
        done_t d;
        int    e;
        @(negedge clk);
        if (dma) begin dma_req = 1; dma_rw = rw; dma_addr = addr; dma_wdata = wdata; end
        else     begin cpu_req = 1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata; end
        e = cyc + 1;
        if (!rw) begin
            if (dma) exp_dma = mem_model(addr); else exp_cpu = mem_model(addr);
        end
        g.dma = dma; g.cyc = e; gq.push_back(g);
        d.dma = dma; d.cyc = e + LAT; d.rdata = dma ? exp_dma : exp_cpu; dq.push_back(d);
        en_cnt = 0; wr_cnt = 0;
        if (drop_early) begin
            wait_gnt(dma, name);
            @(negedge clk);
            drop(dma);
        end
        wait_done(dma, name);
        drop(dma);
        repeat (2) @(negedge clk);
        chk({name, "_en_cycles"}, 64'(en_cnt), 64'(LAT));
    endtask

    initial begin
        gnt_t  g;
        done_t d;
        int    e, n;
        bit    who;

        @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 0);
        rst = 0;

        txn(0, 0, 16'h3000, 16'h0000, 0, "cpu_read");
        txn(1, 1, 16'h4000, 16'hBEEF, 0, "dma_write");
        chk("dma_wr_cycles", 64'(wr_cnt), 64'(LAT));

        // Contention: both held for four grants.
        @(negedge clk);
        cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h1000;
        dma_req = 1; dma_rw = 0; dma_addr = 16'h2000;
        e = cyc + 1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
            who = 1'b0;
`else
            who = (k % 2) == 1;
`endif
            if (who) exp_dma = mem_model(16'h2000); else exp_cpu = mem_model(16'h1000);
            g.dma = who; g.cyc = e + 4 * k; gq.push_back(g);
            d.dma = who; d.cyc = e + 4 * k + LAT; d.rdata = who ? exp_dma : exp_cpu;
            dq.push_back(d);
        end
        n = 0;
        while (gq.size() != 0 && n < 40) begin @(negedge clk); n++; end
        cpu_req = 0; dma_req = 0;
        n = 0;
        while (dq.size() != 0 && n < 20) begin @(negedge clk); n++; end
        chk("contention_drained", 64'(gq.size() + dq.size()), 0);

        txn(0, 0, 16'h0042, 16'h0000, 1, "cpu_drop_early");

        // Reset in the second BUSY cycle of a CPU read.
        @(negedge clk);
        cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h3000;
        g.dma = 0; g.cyc = cyc + 1; gq.push_back(g);
        wait_gnt(0, "rst_busy");
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_busy_outputs", 64'(any_out()), 0);
        cpu_req = 0; exp_cpu = 0; exp_dma = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy_rdata", 64'(cpu_rdata), 0);

        // Grant at the very first edge after reset release.
        cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h5000;
        rst = 0;
        e = cyc + 1;
        exp_cpu = mem_model(16'h5000);
        g.dma = 0; g.cyc = e; gq.push_back(g);
        d.dma = 0; d.cyc = e + LAT; d.rdata = exp_cpu; dq.push_back(d);
        wait_done(0, "post_rst");
        cpu_req = 0;

        // MEM_LAT=1 instance, req dropped one cycle after grant.
        @(negedge clk);
        d1_req = 1; d1_addr = 16'h3000;
        d1q.push_back(cyc + 2);
        n = 0;
        while (!d1_gnt && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        d1_req = 0;
        n = 0;
        while (d1q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        chk("d1_rdata", 64'(d1_rdata), 64'h1234);

        repeat (10) @(negedge clk);
        chk("queues_empty", 64'(gq.size() + dq.size() + d1q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
